instruction_loader: RTL and testbench
=====================================

# instruction_loader

Writes a program into the instruction memory's write port from a byte stream, one 32-bit word at a time, while holding the processor. The datapath fetches from the read side of the same memory. The loader sits between an external byte source (for example a UART receiver or a testbench) and the memory. It asserts `cpuHold` for the whole load so that no fetch sees a partially written program.

## Interface
Parameters:
- `DEPTH`, 32: instruction memory size in words.
- `ADDR_WIDTH`, 5: word-index width, equal to log2(`DEPTH`).

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a load; sampled only in IDLE or DONE.
- `length`  in  ADDR_WIDTH+1  number of words to load, sampled with `start`.
- `abort`  in  1  cancel a load in progress.
- `byteIn`  in  8  incoming program byte.
- `byteValid`  in  1  `byteIn` is valid.
- `byteReady`  out  1  loader accepts a byte this cycle.
- `writeEnable`  out  1  memory write strobe, one cycle per word.
- `writeAddress`  out  32  byte address of the word, equal to word index << 2 (same addressing as the PC).
- `writeData`  out  32  assembled instruction word.
- `cpuHold`  out  1  stall/reset request to the datapath while loading.
- `busy`  out  1  high in RECEIVE or WRITE.
- `done`  out  1  high in DONE.
- `error`  out  1  a load was rejected because `length` > `DEPTH`.

## Operation
- **States:** IDLE, RECEIVE, WRITE, DONE.
- **IDLE:**
  - `start` with `length` = 0 → DONE; no writes occur.
  - `start` with `length` > `DEPTH` → `error` = 1 and the FSM stays in IDLE.
  - Any other `start` → RECEIVE, with word index = 0, byte count = 0, `error` cleared, and `length` latched.
- **RECEIVE:**
  - `byteReady` = 1.
  - A byte is accepted only when `byteValid` & `byteReady`.
  - Packing is little-endian: the k-th accepted byte of a word goes to bits [8k+7:8k].
  - The 4th accepted byte moves the FSM to WRITE.
- **WRITE (exactly one cycle):**
  - `writeEnable` = 1, `byteReady` = 0.
  - `writeAddress` = index << 2, `writeData` = the assembled word.
  - Next state is DONE if index + 1 = the latched length; otherwise index increments and the FSM returns to RECEIVE.
- **DONE:**
  - `done` = 1 and `cpuHold` = 0.
  - `start` is handled as in IDLE, so a reload is possible.
- `cpuHold` = `busy` = 1 in RECEIVE and WRITE only.
- **`abort`:**
  - In RECEIVE, `abort` → IDLE, discarding the partial word; words already written remain in memory. A byte offered in that cycle is not accepted.
  - In WRITE, the write in progress completes and the next state is IDLE.
  - `abort` has priority over the end-of-load transition.
- `start` during RECEIVE or WRITE is ignored.
- Word index and byte count never wrap, because `length` ≤ `DEPTH` is checked on entry.

## Timing
- **Reset values:** all outputs 0 (`byteReady`, `writeEnable`, `writeAddress`, `writeData`, `cpuHold`, `busy`, `done`, `error`). The state returns to IDLE immediately on `reset` low, independent of `clock`; this applies mid-load too, and the partial word is lost.
- **Output style:** all outputs are Moore or registered. `writeData` and `writeAddress` are stable for the whole WRITE cycle.
- **Start latency:** `start` accepted at edge 0 → `byteReady` high from edge 0.
- **Per-word cost:** minimum 5 cycles (4 byte accepts + 1 WRITE). With `byteValid` held high, a load of N words takes 5N cycles from entering RECEIVE to entering DONE.
- **Back-pressure:** `byteValid` gaps only stretch RECEIVE. The source must hold `byteIn` until it is accepted.

## Structure
- **Shared package:**
  - The state enum (IDLE/RECEIVE/WRITE/DONE).
  - `BYTES_PER_WORD` = 4.
  - The default `DEPTH`, shared with the instruction memory so both agree on size.
- **Sub-module:** `byte_packer` holds the shift/insert register and the 2-bit byte counter, and signals when a word is complete. The FSM and address counter stay in the top module.

## Test plan
- **Reset:** hold `reset` low → every output 0. Release reset, then leave `start` = 0 → no `byteReady`, no writes.
- **Two-word load:** `start`, `length` = 2; bytes B3 80 10 00 B3 80 10 00 with continuous valid → writes 0x001080B3 to address 0 and then to address 4. `done` rises 10 cycles after entering RECEIVE, and `cpuHold` is 1 throughout, then 0.
- **Back-pressure:** same load with `byteValid` low for 3 cycles between bytes 2 and 3 → identical writes, no duplicated bytes, WRITE delayed by 3 cycles.
- **Length edge cases:**
  - `length` = 0 → `done` next cycle with no `writeEnable`.
  - `length` = 33 → `error` = 1, stays IDLE, `cpuHold` stays 0.
  - `length` = 32 → last write at address 124.
- **Abort:** `length` = 3; `abort` after 2 bytes of word 1 → only address 0 written; IDLE; `cpuHold` 0. A `start` pulse during RECEIVE has no effect.
- **Async reset mid-load:** `reset` low between clock edges in RECEIVE → outputs 0 before the next edge. A new `start` afterwards reloads from address 0.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the program loader and the instruction memory it fills.
package instruction_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int DEFAULT_DEPTH  = 32;

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface instruction_loader_if;
    logic [7:0]  byteIn;
    logic        byteValid;
    logic        byteReady;
    logic        writeEnable;
    logic [31:0] writeAddress;
    logic [31:0] writeData;

    modport master (
        input  byteIn, byteValid,
        output byteReady, writeEnable, writeAddress, writeData
    );

    modport slave (
        output byteIn, byteValid,
        input  byteReady, writeEnable, writeAddress, writeData
    );
endinterface

// File: rtl/instruction_loader_packer.sv
// Little-endian byte-to-word assembler; flags the byte that completes a word.
module byte_packer
    import instruction_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byteIn,
    output logic [31:0] word,
    output logic        last
);
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  count_r;
    logic [31:0] word_r;

    // Current word with the incoming byte inserted at the active lane
    always_comb begin
        word = word_r;
        case (count_r)
            2'd0:    word[7:0]   = byteIn;
            2'd1:    word[15:8]  = byteIn;
            2'd2:    word[23:16] = byteIn;
            2'd3:    word[31:24] = byteIn;
            default: word        = word_r;
        endcase
        last = accept && (count_r == LAST_BYTE);
    end

    // Byte lane counter and partial word storage
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= 2'd0;
            word_r  <= 32'd0;
        end else if (clear) begin
            count_r <= 2'd0;
            word_r  <= 32'd0;
        end else if (accept) begin
            count_r <= count_r + 2'd1;
            word_r  <= word;
        end
    end
endmodule

// File: rtl/instruction_loader.sv
// Loads a program word by word from a byte stream into instruction memory, holding the CPU meanwhile.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  abort,
    instruction_loader_if.master  bus,
    output logic                  cpuHold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state_r;
    state_t                state_s;
    logic [ADDR_WIDTH-1:0] index_r;
    logic [ADDR_WIDTH:0]   len_r;
    logic                  load_s;
    logic                  reject_s;
    logic                  inc_s;
    logic                  accept_s;
    logic                  clear_s;
    logic                  last_s;
    logic                  final_word_s;
    logic [31:0]           word_s;

    assign accept_s     = (state_r == ST_RECEIVE) && bus.byteValid && !abort;
    assign clear_s      = load_s || ((state_r == ST_RECEIVE) && abort);
    assign final_word_s = (({1'b0, index_r} + (ADDR_WIDTH + 1)'(1)) == len_r);

    byte_packer u_packer (
        .clock  (clock),
        .reset  (reset),
        .clear  (clear_s),
        .accept (accept_s),
        .byteIn (bus.byteIn),
        .word   (word_s),
        .last   (last_s)
    );

    // Next-state logic; abort outranks the end-of-load transition
    always_comb begin
        state_s  = state_r;
        load_s   = 1'b0;
        reject_s = 1'b0;
        inc_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (!start) begin
                    state_s = state_r;
                end else if (length == '0) begin
                    state_s = ST_DONE;
                end else if (length > DEPTH_L) begin
                    state_s  = ST_IDLE;
                    reject_s = 1'b1;
                end else begin
                    state_s = ST_RECEIVE;
                    load_s  = 1'b1;
                end
            end
            ST_RECEIVE: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (last_s) begin
                    state_s = ST_WRITE;
                end else begin
                    state_s = ST_RECEIVE;
                end
            end
            ST_WRITE: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (final_word_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RECEIVE;
                    inc_s   = 1'b1;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, word index, latched length and the sticky length error
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            index_r <= '0;
            len_r   <= '0;
            error   <= 1'b0;
        end else begin
            state_r <= state_s;
            if (load_s) begin
                index_r <= '0;
                len_r   <= length;
                error   <= 1'b0;
            end else if (inc_s) begin
                index_r <= index_r + ADDR_WIDTH'(1);
            end
            if (reject_s) begin
                error <= 1'b1;
            end
        end
    end

    // Outputs registered from the next state so they line up with the state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.byteReady    <= 1'b0;
            bus.writeEnable  <= 1'b0;
            bus.writeAddress <= 32'd0;
            bus.writeData    <= 32'd0;
            cpuHold          <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            bus.byteReady   <= (state_s == ST_RECEIVE);
            bus.writeEnable <= (state_s == ST_WRITE);
            cpuHold         <= (state_s == ST_RECEIVE) || (state_s == ST_WRITE);
            busy            <= (state_s == ST_RECEIVE) || (state_s == ST_WRITE);
            done            <= (state_s == ST_DONE);
            if (last_s && !abort) begin
                bus.writeAddress <= 32'({index_r, 2'b00});
                bus.writeData    <= word_s;
            end
        end
    end
endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench: drivers queue expected memory writes, a monitor pops them on each write strobe.
module tb_instruction_loader;
    import instruction_loader_pkg::*;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW:0]   length = '0;
    logic          cpuHold, busy, done, error;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  n_writes = 0;
    int  cyc = 0;
    int  t0 = 0;
    int  hold_low_cnt = 0;
    bit  track_hold = 1'b0;
    logic [31:0] last_addr = 32'd0;
    wr_t exp_q[$];

    always #5 clock = ~clock;

    instruction_loader_if bus();

    instruction_loader #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .length  (length),
        .abort   (abort),
        .bus     (bus),
        .cpuHold (cpuHold),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest queued expectation
    always @(negedge clock) begin : mon
        wr_t e;
        if (track_hold && done !== 1'b1 && cpuHold !== 1'b1) hold_low_cnt++;
        if (reset === 1'b1 && bus.writeEnable === 1'b1) begin
            n_writes++;
            last_addr = bus.writeAddress;
            check_bit("hold_during_write", cpuHold, 1'b1);
            check_bit("ready_low_in_write", bus.byteReady, 1'b0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write",
                         bus.writeAddress, bus.writeData);
            end else begin
                e = exp_q.pop_front();
                check_word("write_addr", bus.writeAddress, e.addr);
                check_word("write_data", bus.writeData, e.data);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check_bit({tag, "_byteReady"}, bus.byteReady, 1'b0);
        check_bit({tag, "_writeEnable"}, bus.writeEnable, 1'b0);
        check_word({tag, "_writeAddress"}, bus.writeAddress, 32'd0);
        check_word({tag, "_writeData"}, bus.writeData, 32'd0);
        check_bit({tag, "_cpuHold"}, cpuHold, 1'b0);
        check_bit({tag, "_busy"}, busy, 1'b0);
        check_bit({tag, "_done"}, done, 1'b0);
        check_bit({tag, "_error"}, error, 1'b0);
    endtask

    task automatic pulse_start(input int len);
        @(posedge clock); #1;
        start  = 1'b1;
        length = len[AW:0];
        @(posedge clock); #1;
        start  = 1'b0;
        t0     = cyc;
    endtask

    task automatic apply_reset();
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    // Offer one byte after 'gap' idle cycles of junk, return once it is taken
    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        for (int g = 0; g < gap; g++) begin
            bus.byteValid = 1'b0;
            bus.byteIn    = 8'($urandom);
            @(posedge clock); #1;
        end
        bus.byteValid = 1'b1;
        bus.byteIn    = b;
        k = 0;
        @(negedge clock);
        while (bus.byteReady !== 1'b1 && k < 50) begin
            @(negedge clock);
            k++;
        end
        if (k >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL byte_timeout: got byteReady %b expected 1", bus.byteReady);
        end
        @(posedge clock); #1;
        bus.byteValid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        int k;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (done !== 1'b1 && k < 400);
        if (done !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got done %b expected 1", done);
        end
        lat = cyc - t0;
    endtask

    // Load 'len' words from prog; the byte at position gap_at is preceded by gap_len idle cycles
    task automatic run_load(input int len, input logic [7:0] prog[$], input int gap_max,
                            input int gap_at, input int gap_len, output int lat);
        wr_t w;
        int  gap;
        pulse_start(len);
        hold_low_cnt = 0;
        track_hold   = 1'b1;
        for (int wi = 0; wi < len; wi++) begin
            for (int k = 0; k < 4; k++) begin
                if (4 * wi + k == gap_at) gap = gap_len;
                else if (gap_max > 0) gap = $urandom_range(gap_max, 0);
                else gap = 0;
                send_byte(prog[4 * wi + k], gap);
            end
            w.addr = 32'(wi * 4);
            w.data = 32'(prog[4*wi]) + 32'(prog[4*wi+1]) * 32'd256
                   + 32'(prog[4*wi+2]) * 32'd65536 + 32'(prog[4*wi+3]) * 32'd16777216;
            exp_q.push_back(w);
        end
        wait_done(lat);
        track_hold = 1'b0;
        check_word("hold_throughout_load", 32'(hold_low_cnt), 32'd0);
        check_bit("hold_after_done", cpuHold, 1'b0);
        check_bit("busy_after_done", busy, 1'b0);
    endtask

    initial begin
        logic [7:0] prog[$];
        int lat;
        int nw;
        wr_t w;

        bus.byteIn    = 8'h00;
        bus.byteValid = 1'b0;

        #23;
        check_all_zero("reset");
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (5) @(negedge clock);
        check_bit("idle_ready", bus.byteReady, 1'b0);
        check_bit("idle_hold", cpuHold, 1'b0);
        check_word("idle_writes", 32'(n_writes), 32'd0);

        pulse_start(0);
        @(negedge clock);
        check_bit("len0_done", done, 1'b1);
        check_bit("len0_hold", cpuHold, 1'b0);
        repeat (3) @(negedge clock);
        check_word("len0_writes", 32'(n_writes), 32'd0);

        apply_reset();
        pulse_start(33);
        repeat (3) begin
            @(negedge clock);
            check_bit("len33_error", error, 1'b1);
            check_bit("len33_hold", cpuHold, 1'b0);
            check_bit("len33_ready", bus.byteReady, 1'b0);
            check_bit("len33_done", done, 1'b0);
        end

        prog = '{8'hB3, 8'h80, 8'h10, 8'h00, 8'hB3, 8'h80, 8'h10, 8'h00};
        run_load(2, prog, 0, -1, 0, lat);
        check_word("two_word_latency", 32'(lat), 32'd10);
        check_bit("error_cleared", error, 1'b0);
        run_load(2, prog, 0, 2, 3, lat);
        check_word("backpressure_latency", 32'(lat), 32'd13);

        prog.delete();
        for (int i = 0; i < 4 * DEPTH; i++) prog.push_back(8'($urandom));
        nw = n_writes;
        run_load(32, prog, 0, -1, 0, lat);
        check_word("len32_latency", 32'(lat), 32'd160);
        check_word("len32_last_addr", last_addr, 32'd124);
        check_word("len32_count", 32'(n_writes - nw), 32'd32);

        // Abort during word 1; a start pulse in RECEIVE must not restart the load
        nw = n_writes;
        prog = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        pulse_start(3);
        send_byte(prog[0], 0);
        start  = 1'b1;
        length = 6'd1;
        @(posedge clock); #1;
        start  = 1'b0;
        for (int k = 1; k < 4; k++) send_byte(prog[k], 0);
        w.addr = 32'd0;
        w.data = 32'h44332211;
        exp_q.push_back(w);
        send_byte(prog[4], 0);
        send_byte(prog[5], 0);
        bus.byteValid = 1'b1;
        bus.byteIn    = 8'h77;
        abort         = 1'b1;
        @(posedge clock); #1;
        abort         = 1'b0;
        bus.byteValid = 1'b0;
        @(negedge clock);
        check_bit("abort_hold", cpuHold, 1'b0);
        check_bit("abort_busy", busy, 1'b0);
        check_bit("abort_done", done, 1'b0);
        check_bit("abort_ready", bus.byteReady, 1'b0);
        repeat (10) @(negedge clock);
        check_word("abort_writes", 32'(n_writes - nw), 32'd1);

        // Asynchronous reset between edges while receiving
        pulse_start(2);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        @(negedge clock); #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clock); #1;
        reset = 1'b1;
        prog = '{8'h13, 8'h05, 8'h10, 8'h00};
        run_load(1, prog, 0, -1, 0, lat);
        check_word("reload_latency", 32'(lat), 32'd5);

        for (int r = 0; r < 6; r++) begin
            int len;
            len = $urandom_range(6, 1);
            prog.delete();
            for (int i = 0; i < 4 * len; i++) prog.push_back(8'($urandom));
            run_load(len, prog, 2, -1, 0, lat);
            check_bit("random_done", done, 1'b1);
        end

        repeat (3) @(negedge clock);
        check_word("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
